lvl4_node_lookup: RTL

- Level-4 search stage of the two-lane MBitTree classifier pipeline. Sits directly downstream of the level-3/level-4 pipeline register.
- For each lane it takes the packet header, current node and matched flag. It extracts the 2 header bits the node selects and reads the child node from a local node memory.
- It then presents packet, child node, valid and matched to the next register stage.
- A shared write port lets the control plane update the level-4 node memory in service.

---
 rtl/lvl4_node_lookup.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/lvl4_node_lookup.sv
// Level-4 MBitTree search stage: per lane, pick two header bits selected by the
// current node, read the child node from local memory, and forward 2 cycles later.
module lvl4_node_lookup #(
    parameter int PACKET_WIDTH = 104,
    parameter int NODE_WIDTH   = 40,
    parameter int ADDR_WIDTH   = 10,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    RST,
    input  logic [PACKET_WIDTH-1:0] packet_in1,
    input  logic [PACKET_WIDTH-1:0] packet_in2,
    input  logic                    data_valid_in1,
    input  logic                    data_valid_in2,
    input  logic [NODE_WIDTH-1:0]   node_in1,
    input  logic [NODE_WIDTH-1:0]   node_in2,
    input  logic                    matched_in1,
    input  logic                    matched_in2,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [NODE_WIDTH-1:0]   wr_data,
    output logic [PACKET_WIDTH-1:0] packet_out1,
    output logic [PACKET_WIDTH-1:0] packet_out2,
    output logic                    data_valid_out1,
    output logic                    data_valid_out2,
    output logic [NODE_WIDTH-1:0]   node_out1,
    output logic [NODE_WIDTH-1:0]   node_out2,
    output logic                    matched_out1,
    output logic                    matched_out2,
    output logic [CNT_WIDTH-1:0]    lookup_cnt,
    output logic [CNT_WIDTH-1:0]    bypass_cnt
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        CLS_INV = 2'd0,
        CLS_BYP = 2'd1,
        CLS_LKP = 2'd2
    } cls_e;

    // Header bit p is packet[p]; positions past the header read as 0.
    function automatic logic hdr_bit(input logic [PACKET_WIDTH-1:0] pkt,
                                     input logic [6:0]              pos);
        if (int'(pos) >= PACKET_WIDTH) return 1'b0;
        return pkt[pos];
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] child_addr(
        input logic [PACKET_WIDTH-1:0] pkt,
        input logic [6:0]              pos0,
        input logic [6:0]              pos1,
        input logic [ADDR_WIDTH-1:0]   base
    );
        logic [1:0] sel;
        sel = {hdr_bit(pkt, pos1), hdr_bit(pkt, pos0)};
        return base + ADDR_WIDTH'(sel);
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                     input logic [1:0]           inc);
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, cnt} + {{(CNT_WIDTH-1){1'b0}}, inc};
        return sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
    endfunction

    logic [NODE_WIDTH-1:0]   mem [DEPTH];

    logic [PACKET_WIDTH-1:0] pkt_in  [2];
    logic [NODE_WIDTH-1:0]   node_in [2];
    logic                    vld_in  [2];
    logic                    mat_in  [2];

    assign pkt_in[0]  = packet_in1;
    assign pkt_in[1]  = packet_in2;
    assign node_in[0] = node_in1;
    assign node_in[1] = node_in2;
    assign vld_in[0]  = data_valid_in1;
    assign vld_in[1]  = data_valid_in2;
    assign mat_in[0]  = matched_in1;
    assign mat_in[1]  = matched_in2;

    logic [ADDR_WIDTH-1:0]   addr_d      [2];
    cls_e                    cls_p1_d    [2];
    cls_e                    cls_p1_q    [2];
    logic [PACKET_WIDTH-1:0] pkt_p1_d    [2];
    logic [PACKET_WIDTH-1:0] pkt_p1_q    [2];
    logic [NODE_WIDTH-1:0]   node_p1_d   [2];
    logic [NODE_WIDTH-1:0]   node_p1_q   [2];
    logic [NODE_WIDTH-1:0]   rd_data_p1_q[2];

    logic [PACKET_WIDTH-1:0] pkt_out_d   [2];
    logic [PACKET_WIDTH-1:0] pkt_out_q   [2];
    logic [NODE_WIDTH-1:0]   node_out_d  [2];
    logic [NODE_WIDTH-1:0]   node_out_q  [2];
    logic                    vld_out_d   [2];
    logic                    vld_out_q   [2];
    logic                    mat_out_d   [2];
    logic                    mat_out_q   [2];
    logic [CNT_WIDTH-1:0]    lookup_cnt_d, lookup_cnt_q;
    logic [CNT_WIDTH-1:0]    bypass_cnt_d, bypass_cnt_q;
    logic [1:0]              n_lkp, n_byp;

    // Stage 1: classify the beat and form the child address
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            addr_d[i] = child_addr(pkt_in[i],
                                   node_in[i][NODE_WIDTH-2 -: 7],
                                   node_in[i][NODE_WIDTH-9 -: 7],
                                   node_in[i][ADDR_WIDTH-1:0]);
            if (!vld_in[i])
                cls_p1_d[i] = CLS_INV;
            else if (mat_in[i] || node_in[i][NODE_WIDTH-1])
                cls_p1_d[i] = CLS_BYP;
            else
                cls_p1_d[i] = CLS_LKP;
            pkt_p1_d[i]  = pkt_in[i];
            node_p1_d[i] = node_in[i];
        end
    end

    // Node memory: contents survive reset; reads see pre-write data (read-first)
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        for (int i = 0; i < 2; i++) rd_data_p1_q[i] <= mem[addr_d[i]];
    end

    // Stage 2: select child or passed-through node, tally lane classes
    always_comb begin
        n_lkp = 2'd0;
        n_byp = 2'd0;
        for (int i = 0; i < 2; i++) begin
            pkt_out_d[i]  = pkt_p1_q[i];
            node_out_d[i] = '0;
            vld_out_d[i]  = 1'b0;
            mat_out_d[i]  = 1'b0;
            case (cls_p1_q[i])
                CLS_LKP: begin
                    node_out_d[i] = rd_data_p1_q[i];
                    vld_out_d[i]  = 1'b1;
                    n_lkp         = n_lkp + 2'd1;
                end
                CLS_BYP: begin
                    node_out_d[i] = node_p1_q[i];
                    vld_out_d[i]  = 1'b1;
                    mat_out_d[i]  = 1'b1;
                    n_byp         = n_byp + 2'd1;
                end
                default: ;
            endcase
        end
        lookup_cnt_d = sat_add(lookup_cnt_q, n_lkp);
        bypass_cnt_d = sat_add(bypass_cnt_q, n_byp);
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 2; i++) begin
                cls_p1_q[i]   <= CLS_INV;
                pkt_p1_q[i]   <= '0;
                node_p1_q[i]  <= '0;
                pkt_out_q[i]  <= '0;
                node_out_q[i] <= '0;
                vld_out_q[i]  <= 1'b0;
                mat_out_q[i]  <= 1'b0;
            end
            lookup_cnt_q <= '0;
            bypass_cnt_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                cls_p1_q[i]   <= cls_p1_d[i];
                pkt_p1_q[i]   <= pkt_p1_d[i];
                node_p1_q[i]  <= node_p1_d[i];
                pkt_out_q[i]  <= pkt_out_d[i];
                node_out_q[i] <= node_out_d[i];
                vld_out_q[i]  <= vld_out_d[i];
                mat_out_q[i]  <= mat_out_d[i];
            end
            lookup_cnt_q <= lookup_cnt_d;
            bypass_cnt_q <= bypass_cnt_d;
        end
    end

    assign packet_out1     = pkt_out_q[0];
    assign packet_out2     = pkt_out_q[1];
    assign data_valid_out1 = vld_out_q[0];
    assign data_valid_out2 = vld_out_q[1];
    assign node_out1       = node_out_q[0];
    assign node_out2       = node_out_q[1];
    assign matched_out1    = mat_out_q[0];
    assign matched_out2    = mat_out_q[1];
    assign lookup_cnt      = lookup_cnt_q;
    assign bypass_cnt      = bypass_cnt_q;

endmodule
